// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide unit with HI/LO registers for the MIPS datapath.
//   mult/multu use radix-2 add-and-shift; div/divu use restoring division.
//   Each operation spends WIDTH cycles in RUN and one cycle in FIX, then
//   writes HI/LO on entry to DONE. done pulses for one cycle in DONE.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   start, op     launch request (accepted in IDLE only);
//                 op: 00 multu, 01 mult, 10 divu, 11 div
//   a, b          operands (Rs, Rt), sampled when start is accepted
//   hi_we, lo_we  mthi / mtlo strobes using wdata (ignored while busy)
//   abort         cancel the in-flight op (only with MULDIV_ABORT_EN)
//   busy          op in flight (RUN or FIX)
//   done          one-cycle pulse; hi/lo hold the new result
//   div_by_zero   pulses with done when a divide had b == 0
//   hi, lo        architectural HI/LO registers
//
// Configuration macro: MULDIV_ABORT_EN adds the abort port.

module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [5:0]       count;
    logic             is_div, sign_a, sign_b, b_zero, dbz_r;
    logic [WIDTH-1:0] acc;     // mul: running upper product; div: partial remainder
    logic [WIDTH-1:0] q;       // mul: multiplier/lower product; div: dividend/quotient
    logic [WIDTH-1:0] m;       // mul: multiplicand; div: divisor
    logic [WIDTH-1:0] a_orig;  // original dividend, returned in HI on divide by zero
    logic             abort_req;

`ifdef MULDIV_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Combinational helpers: operand magnitudes, one loop step, sign correction.
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        mag_a     = (op[0] && a[WIDTH-1]) ? -a : a;
        mag_b     = (op[0] && b[WIDTH-1]) ? -b : b;
        mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        div_shift = {acc, q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m};
        prod      = {acc, q};
        prod_fix  = (sign_a ^ sign_b) ? -prod : prod;
        res_hi    = prod_fix[2*WIDTH-1:WIDTH];
        res_lo    = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                res_lo = '1;
                res_hi = a_orig;
            end else begin
                // Quotient negated when signs differ; remainder follows the dividend.
                res_lo = (sign_a ^ sign_b) ? -q : q;
                res_hi = sign_a ? -acc : acc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (abort_req) state_nxt = IDLE;
                     else if (count == LAST) state_nxt = FIX;
            FIX:     state_nxt = abort_req ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state == RUN) || (state == FIX);
    assign done        = (state == DONE);
    assign div_by_zero = (state == DONE) && dbz_r;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Working registers of the iterative loop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            a_orig <= '0;
        end else if (state == IDLE && start) begin
            count  <= '0;
            is_div <= op[1];
            sign_a <= op[0] && a[WIDTH-1];
            sign_b <= op[0] && b[WIDTH-1];
            b_zero <= (b == '0);
            a_orig <= a;
            acc    <= '0;
            q      <= op[1] ? mag_a : mag_b;
            m      <= op[1] ? mag_b : mag_a;
        end else if (state == RUN) begin
            count <= count + 6'd1;
            if (is_div) begin
                // Restoring step: keep the difference only when it is non-negative.
                acc <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
                acc <= mul_sum[WIDTH:1];
                q   <= {mul_sum[0], q[WIDTH-1:1]};
            end
        end
    end

    // HI/LO: the result write on FIX->DONE outranks any software write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            dbz_r <= 1'b0;
        end else if (state == FIX) begin
            if (!abort_req) begin
                hi    <= res_hi;
                lo    <= res_lo;
                dbz_r <= is_div && b_zero;
            end
        end else if (!busy) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule
